// File: rtl/fx2_write_arbiter.sv
// Arbitrates the FX2 slave-FIFO write port between a non-stallable capture stream (FIFO4)
// and a flow-controlled status stream (FIFO5), with FIFOADR settling and idle PKTEND flushing.
module fx2_write_arbiter #(
    parameter logic [1:0] CAP_ADDR     = 2'b10,
    parameter logic [1:0] STAT_ADDR    = 2'b11,
    parameter int         ADDR_SETTLE  = 1,
    parameter int         FLUSH_CYCLES = 48000
) (
    input  logic        FIFO_clk,
    input  logic        reset,
    input  logic        cap_strobe,
    input  logic [7:0]  cap_data,
    input  logic        stat_valid,
    input  logic [7:0]  stat_data,
    output logic        stat_ready,
    input  logic        FIFO4_ready,
    input  logic        FIFO5_ready,
    output logic        FIFO_WR,
    output logic        FIFO_PKTEND,
    output logic [1:0]  FIFO_FIFOADR,
    output logic [7:0]  FIFO_DATAOUT,
    output logic        cap_lost,
    output logic [15:0] cap_lost_count
);

    localparam int            TW          = $clog2(FLUSH_CYCLES + 1);
    localparam logic [TW-1:0] FLUSH_LIMIT = TW'(FLUSH_CYCLES);
    localparam logic [1:0]    SETTLE_LAST = 2'(ADDR_SETTLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        CAP_SEL,
        STAT_SEL,
        CAP_WR,
        STAT_WR,
        FLUSH_SEL,
        FLUSH
    } state_t;

    state_t        state;
    state_t        state_n;
    logic          hold_full;
    logic [7:0]    hold_data;
    logic          pend4;
    logic          pend5;
    logic [TW-1:0] flush_timer;
    logic [1:0]    settle_cnt;

    logic          wr_cap;
    logic          wr_stat;
    logic          pkt_go;
    logic          settle_clr;
    logic [1:0]    adr_n;
    logic [1:0]    flush_target;
    logic          flush_due;
    logic          settle_done;
    logic          cap_drop;

    assign flush_due    = (flush_timer == FLUSH_LIMIT);
    assign settle_done  = (settle_cnt == SETTLE_LAST);
    assign flush_target = pend4 ? CAP_ADDR : STAT_ADDR;
    // A byte is lost only when the holding register stays occupied through this cycle.
    assign cap_drop     = cap_strobe && hold_full && !wr_cap;

    // Write decisions are made here; the FX2 pins follow one cycle later.
    always_comb begin
        state_n    = state;
        wr_cap     = 1'b0;
        wr_stat    = 1'b0;
        pkt_go     = 1'b0;
        settle_clr = 1'b0;
        adr_n      = FIFO_FIFOADR;
        stat_ready = 1'b0;
        case (state)
            IDLE: begin
                if (hold_full && FIFO_FIFOADR == CAP_ADDR) begin
                    state_n = CAP_WR;
                    wr_cap  = FIFO4_ready;
                end else if (hold_full) begin
                    state_n    = CAP_SEL;
                    adr_n      = CAP_ADDR;
                    settle_clr = 1'b1;
                end else if (stat_valid) begin
                    if (FIFO_FIFOADR == STAT_ADDR) begin
                        state_n = STAT_WR;
                    end else begin
                        state_n    = STAT_SEL;
                        adr_n      = STAT_ADDR;
                        settle_clr = 1'b1;
                    end
                end else if (flush_due && (pend4 || pend5)) begin
                    if (FIFO_FIFOADR == flush_target) begin
                        state_n = FLUSH;
                    end else begin
                        state_n    = FLUSH_SEL;
                        adr_n      = flush_target;
                        settle_clr = 1'b1;
                    end
                end
            end
            CAP_SEL: begin
                if (settle_done) state_n = CAP_WR;
            end
            STAT_SEL: begin
                if (settle_done) state_n = STAT_WR;
            end
            FLUSH_SEL: begin
                if (settle_done) state_n = FLUSH;
            end
            CAP_WR: begin
                if (hold_full) begin
                    wr_cap = FIFO4_ready;
                end else if (stat_valid) begin
                    state_n    = STAT_SEL;
                    adr_n      = STAT_ADDR;
                    settle_clr = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            STAT_WR: begin
                // Capture preempts a status burst; no handshake in the switching cycle.
                if (hold_full) begin
                    state_n    = CAP_SEL;
                    adr_n      = CAP_ADDR;
                    settle_clr = 1'b1;
                end else if (!stat_valid) begin
                    state_n = IDLE;
                end else begin
                    stat_ready = FIFO5_ready;
                    wr_stat    = FIFO5_ready;
                end
            end
            FLUSH: begin
                pkt_go  = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge FIFO_clk) begin
        if (reset) begin
            state      <= IDLE;
            settle_cnt <= 2'd0;
        end else begin
            state <= state_n;
            if (settle_clr) begin
                settle_cnt <= 2'd0;
            end else if (state inside {CAP_SEL, STAT_SEL, FLUSH_SEL}) begin
                settle_cnt <= settle_cnt + 2'd1;
            end
        end
    end

    // Registered FX2 pins: WR, PKTEND, address and data all change on the same edge.
    always_ff @(posedge FIFO_clk) begin
        if (reset) begin
            FIFO_WR      <= 1'b0;
            FIFO_PKTEND  <= 1'b0;
            FIFO_FIFOADR <= CAP_ADDR;
            FIFO_DATAOUT <= 8'h00;
        end else begin
            FIFO_WR      <= wr_cap || wr_stat;
            FIFO_PKTEND  <= pkt_go;
            FIFO_FIFOADR <= adr_n;
            if (wr_cap) begin
                FIFO_DATAOUT <= hold_data;
            end else if (wr_stat) begin
                FIFO_DATAOUT <= stat_data;
            end
        end
    end

    always_ff @(posedge FIFO_clk) begin
        if (reset) begin
            hold_full <= 1'b0;
            hold_data <= 8'h00;
        end else if (cap_strobe && (!hold_full || wr_cap)) begin
            hold_full <= 1'b1;
            hold_data <= cap_data;
        end else if (wr_cap) begin
            hold_full <= 1'b0;
        end
    end

    always_ff @(posedge FIFO_clk) begin
        if (reset) begin
            cap_lost       <= 1'b0;
            cap_lost_count <= 16'h0000;
        end else begin
            cap_lost <= cap_drop;
            if (cap_drop && cap_lost_count != 16'hFFFF) begin
                cap_lost_count <= cap_lost_count + 16'd1;
            end
        end
    end

    // Pending-packet flags and the idle timer that decides when a short packet is pushed out.
    always_ff @(posedge FIFO_clk) begin
        if (reset) begin
            pend4       <= 1'b0;
            pend5       <= 1'b0;
            flush_timer <= '0;
        end else begin
            if (wr_cap) begin
                pend4 <= 1'b1;
            end else if (pkt_go && flush_target == CAP_ADDR) begin
                pend4 <= 1'b0;
            end
            if (wr_stat) begin
                pend5 <= 1'b1;
            end else if (pkt_go && flush_target == STAT_ADDR) begin
                pend5 <= 1'b0;
            end
            if (FIFO_WR) begin
                flush_timer <= '0;
            end else if (!flush_due) begin
                flush_timer <= flush_timer + TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fx2_write_arbiter.sv
// Scoreboard bench for fx2_write_arbiter: directed scenarios plus a randomized phase,
// checked against a stream-level model of the capture holding rule and status handshakes.
module tb_fx2_write_arbiter;

    localparam logic [1:0] CAP_ADDR     = 2'b10;
    localparam logic [1:0] STAT_ADDR    = 2'b11;
    localparam int         ADDR_SETTLE  = 2;
    localparam int         FLUSH_CYCLES = 200;

    logic        FIFO_clk = 1'b0;
    logic        reset;
    logic        cap_strobe;
    logic [7:0]  cap_data;
    logic        stat_valid;
    logic [7:0]  stat_data;
    logic        stat_ready;
    logic        FIFO4_ready;
    logic        FIFO5_ready;
    logic        FIFO_WR;
    logic        FIFO_PKTEND;
    logic [1:0]  FIFO_FIFOADR;
    logic [7:0]  FIFO_DATAOUT;
    logic        cap_lost;
    logic [15:0] cap_lost_count;

    fx2_write_arbiter #(
        .CAP_ADDR    (CAP_ADDR),
        .STAT_ADDR   (STAT_ADDR),
        .ADDR_SETTLE (ADDR_SETTLE),
        .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .FIFO_clk      (FIFO_clk),
        .reset         (reset),
        .cap_strobe    (cap_strobe),
        .cap_data      (cap_data),
        .stat_valid    (stat_valid),
        .stat_data     (stat_data),
        .stat_ready    (stat_ready),
        .FIFO4_ready   (FIFO4_ready),
        .FIFO5_ready   (FIFO5_ready),
        .FIFO_WR       (FIFO_WR),
        .FIFO_PKTEND   (FIFO_PKTEND),
        .FIFO_FIFOADR  (FIFO_FIFOADR),
        .FIFO_DATAOUT  (FIFO_DATAOUT),
        .cap_lost      (cap_lost),
        .cap_lost_count(cap_lost_count)
    );

    always #5 FIFO_clk = ~FIFO_clk;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } cap_ent_t;

    typedef struct {
        bit         is_cap;
        logic [7:0] d;
    } wlog_t;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    cap_ent_t   cap_q[$];
    logic [7:0] stat_q[$];
    logic [7:0] stat_src[$];
    wlog_t      wlog[$];
    int         drops = 0;
    int         lost_pulses = 0;
    int         cap_writes = 0;
    int         stat_writes = 0;
    int         pkt_count = 0;
    int         quiet = 0;
    int         settle_quiet = 0;
    bit         m_pend4 = 1'b0;
    bit         m_pend5 = 1'b0;
    bit         last_hs = 1'b0;
    logic [1:0] prev_adr = 2'b00;
    logic [7:0] last_cap_data = 8'h00;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int satCount(input int n);
        return (n > 65535) ? 65535 : n;
    endfunction

    // Monitor/scoreboard: samples everything on the falling edge, away from the active edge.
    always @(negedge FIFO_clk) begin
        cap_ent_t ent;
        logic [7:0] sd;
        cyc++;
        if (reset) begin
            cap_q.delete();
            stat_q.delete();
            drops        = 0;
            lost_pulses  = 0;
            m_pend4      = 1'b0;
            m_pend5      = 1'b0;
            last_hs      = 1'b0;
            quiet        = 0;
            settle_quiet = ADDR_SETTLE;
            prev_adr     = FIFO_FIFOADR;
        end else begin
            if (FIFO_WR || FIFO_PKTEND) begin
                checkOutput("wr_pktend_exclusive", FIFO_WR & FIFO_PKTEND, 0);
                checkOutput("adr_stable_on_strobe", FIFO_FIFOADR, prev_adr);
                checkOutput("adr_settled", settle_quiet >= ADDR_SETTLE, 1);
            end
            if (FIFO_WR) begin
                if (FIFO_FIFOADR == CAP_ADDR) begin
                    cap_writes++;
                    m_pend4       = 1'b1;
                    last_cap_data = FIFO_DATAOUT;
                    wlog.push_back('{1'b1, FIFO_DATAOUT});
                    if (cap_q.size() == 0) begin
                        checkOutput("cap_write_unexpected", 1, 0);
                    end else begin
                        // Oldest pending byte is the held one; later bytes strobed before
                        // the drain cycle found the register full and were dropped.
                        ent = cap_q.pop_front();
                        checkOutput("cap_data", FIFO_DATAOUT, ent.data);
                        while (cap_q.size() > 0 && cap_q[0].cyc < cyc - 1) begin
                            cap_q.delete(0);
                            drops++;
                        end
                    end
                end else if (FIFO_FIFOADR == STAT_ADDR) begin
                    stat_writes++;
                    m_pend5 = 1'b1;
                    wlog.push_back('{1'b0, FIFO_DATAOUT});
                    if (stat_q.size() == 0) begin
                        checkOutput("stat_write_unexpected", 1, 0);
                    end else begin
                        sd = stat_q.pop_front();
                        checkOutput("stat_data", FIFO_DATAOUT, sd);
                    end
                end else begin
                    checkOutput("wr_fifoadr", FIFO_FIFOADR, CAP_ADDR);
                end
            end
            if (FIFO_PKTEND) begin
                pkt_count++;
                checkOutput("pktend_after_idle", quiet >= FLUSH_CYCLES, 1);
                if (m_pend4) begin
                    checkOutput("pktend_adr_cap_first", FIFO_FIFOADR, CAP_ADDR);
                    m_pend4 = 1'b0;
                end else if (m_pend5) begin
                    checkOutput("pktend_adr_stat", FIFO_FIFOADR, STAT_ADDR);
                    m_pend5 = 1'b0;
                end else begin
                    checkOutput("pktend_without_pend", 1, 0);
                end
            end
            if (cap_lost) lost_pulses++;
            last_hs = stat_valid && stat_ready;
            if (last_hs) stat_q.push_back(stat_data);
            if (cap_strobe) cap_q.push_back('{cap_data, cyc});
            if (FIFO_FIFOADR != prev_adr) settle_quiet = 0;
            else if (!FIFO_WR && !FIFO_PKTEND) settle_quiet++;
            if (FIFO_WR) quiet = 0;
            else quiet++;
            prev_adr = FIFO_FIFOADR;
        end
    end

    // One cycle of stimulus; the status source presents the head of stat_src until accepted.
    task automatic applyStimulus(input logic cs, input logic [7:0] cd, input logic f4, input logic f5);
        @(posedge FIFO_clk);
        #1;
        if (last_hs && stat_src.size() > 0) stat_src.delete(0);
        cap_strobe  = cs;
        cap_data    = cd;
        FIFO4_ready = f4;
        FIFO5_ready = f5;
        stat_valid  = (stat_src.size() > 0);
        stat_data   = (stat_src.size() > 0) ? stat_src[0] : 8'h00;
    endtask

    task automatic idleCycles(input int n, input logic f4);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, f4, 1'b1);
    endtask

    task automatic resetDut();
        reset       = 1'b1;
        cap_strobe  = 1'b0;
        cap_data    = 8'h00;
        stat_valid  = 1'b0;
        stat_data   = 8'h00;
        FIFO4_ready = 1'b1;
        FIFO5_ready = 1'b1;
        stat_src.delete();
        repeat (2) @(posedge FIFO_clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_wr"}, FIFO_WR, 0);
        checkOutput({tag, "_pktend"}, FIFO_PKTEND, 0);
        checkOutput({tag, "_fifoadr"}, FIFO_FIFOADR, CAP_ADDR);
        checkOutput({tag, "_dataout"}, FIFO_DATAOUT, 0);
        checkOutput({tag, "_stat_ready"}, stat_ready, 0);
        checkOutput({tag, "_cap_lost"}, cap_lost, 0);
        checkOutput({tag, "_lost_count"}, cap_lost_count, 0);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int w0;
        int s0;
        int p0;
        int cap_idx;
        bit done;

        resetDut();
        checkResetValues("reset");

        // Nothing written yet, so the idle timer must never produce PKTEND.
        p0 = pkt_count;
        idleCycles(FLUSH_CYCLES + 20, 1'b1);
        checkOutput("no_pend_no_pktend", pkt_count - p0, 0);

        // Ten back-to-back capture bytes with FIFO4 ready.
        w0 = cap_writes;
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'(i), 1'b1, 1'b1);
        idleCycles(10, 1'b1);
        checkOutput("t1_cap_writes", cap_writes - w0, 10);
        checkOutput("t1_queue_empty", cap_q.size(), 0);
        checkOutput("t1_lost_count", cap_lost_count, 0);

        // FIFO4 full: first byte held, the other four dropped.
        w0 = cap_writes;
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'h20 + 8'(i), 1'b0, 1'b1);
        idleCycles(5, 1'b0);
        checkOutput("t2_no_write_while_full", cap_writes - w0, 0);
        checkOutput("t2_lost_count", cap_lost_count, 4);
        checkOutput("t2_lost_pulses", lost_pulses, 4);
        idleCycles(10, 1'b1);
        checkOutput("t2_single_write", cap_writes - w0, 1);
        checkOutput("t2_held_byte", last_cap_data, 8'h20);
        checkOutput("t2_model_drops", cap_lost_count, satCount(drops));

        // Status burst on its own, then a burst interrupted by a capture byte.
        s0 = stat_writes;
        stat_src.push_back(8'hA1);
        stat_src.push_back(8'hA2);
        stat_src.push_back(8'hA3);
        idleCycles(30, 1'b1);
        checkOutput("t3_stat_writes", stat_writes - s0, 3);
        checkOutput("t3_fifoadr_stat", FIFO_FIFOADR, STAT_ADDR);
        checkOutput("t3_src_drained", stat_src.size(), 0);

        wlog.delete();
        s0 = stat_writes;
        for (int i = 1; i <= 6; i++) stat_src.push_back(8'hB0 + 8'(i));
        done = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
            done = (stat_writes > s0);
        end
        checkOutput("t3_burst_started", done, 1);
        applyStimulus(1'b1, 8'h5C, 1'b1, 1'b1);
        idleCycles(40, 1'b1);
        checkOutput("t3_log_len", wlog.size(), 7);
        cap_idx = -1;
        foreach (wlog[k]) if (wlog[k].is_cap) cap_idx = k;
        checkOutput("t3_cap_after_first_stat", cap_idx > 0, 1);
        checkOutput("t3_stat_after_cap", (cap_idx >= 0) && (cap_idx < wlog.size() - 1), 1);
        checkOutput("t3_last_is_B6", (wlog.size() > 0) ? {wlog[wlog.size()-1].is_cap, wlog[wlog.size()-1].d} : 9'h1FF, {1'b0, 8'hB6});

        // One capture byte then silence: exactly one PKTEND on the capture endpoint.
        resetDut();
        p0 = pkt_count;
        applyStimulus(1'b1, 8'h77, 1'b1, 1'b1);
        idleCycles(FLUSH_CYCLES + 10, 1'b1);
        checkOutput("t4_one_pktend", pkt_count - p0, 1);
        checkOutput("t4_pend4_cleared", m_pend4, 0);
        idleCycles(FLUSH_CYCLES + 20, 1'b1);
        checkOutput("t4_no_second_pktend", pkt_count - p0, 1);

        // Lost-byte counter saturation with FIFO4 permanently full.
        resetDut();
        for (int i = 0; i < 101; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("t5_count_100", cap_lost_count, 100);
        for (int i = 101; i < 65600; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b1);
        idleCycles(3, 1'b0);
        checkOutput("t5_saturated", cap_lost_count, 16'hFFFF);
        checkOutput("t5_pulses", lost_pulses, 65599);
        w0 = cap_writes;
        idleCycles(10, 1'b1);
        checkOutput("t5_drain_write", cap_writes - w0, 1);
        checkOutput("t5_held_byte", last_cap_data, 8'h00);
        checkOutput("t5_no_wrap", cap_lost_count, satCount(drops));

        // Reset while switching to the status endpoint.
        stat_src.push_back(8'hC1);
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
            done = (FIFO_FIFOADR == STAT_ADDR);
        end
        checkOutput("t6_reached_stat_sel", done, 1);
        reset = 1'b1;
        @(posedge FIFO_clk);
        #1;
        checkResetValues("t6");
        stat_src.delete();
        stat_valid = 1'b0;
        @(posedge FIFO_clk);
        #1;
        reset = 1'b0;

        // Randomized traffic on both streams with random backpressure.
        resetDut();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 20 && stat_src.size() < 8) stat_src.push_back(8'($urandom));
            applyStimulus($urandom_range(0, 99) < 35, 8'($urandom), $urandom_range(0, 99) < 85,
                          $urandom_range(0, 99) < 80);
        end
        idleCycles(200, 1'b1);
        checkOutput("rand_cap_q_empty", cap_q.size(), 0);
        checkOutput("rand_stat_q_empty", stat_q.size(), 0);
        checkOutput("rand_src_drained", stat_src.size(), 0);
        checkOutput("rand_lost_count", cap_lost_count, satCount(drops));
        checkOutput("rand_lost_pulses", lost_pulses, drops);
        idleCycles(FLUSH_CYCLES + 60, 1'b1);
        checkOutput("rand_pend_flushed", {m_pend4, m_pend5}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
